// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: RV32 IF stage with PC, next-PC select, imem handshake, IF/ID register
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] PC,
  output logic [31:0] IF_INSTRUCTION,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC_PLUS4,
  output logic        IF_VALID
);
  typedef enum logic {FETCH, DRAIN} state_t;
  state_t state, state_next;
  logic [31:0] drain_addr;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  assign pc_plus4 = PC + 32'd4;
  assign target   = {BRANCH_TARGET[31:2], 2'b00};
  // DRAIN keeps presenting the abandoned address until memory finishes with it
  always_comb begin
    state_next   = state;
    IMEM_READ    = !RESET;
    IMEM_ADDRESS = (state == DRAIN) ? drain_addr : PC;
    state_next   = (state == DRAIN) ? (IMEM_BUSYWAIT ? DRAIN : FETCH)
                                    : ((BRANCH_TAKEN && IMEM_BUSYWAIT) ? DRAIN : FETCH);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= FETCH;
      PC             <= RESET_PC;
      drain_addr     <= 32'd0;
      IF_INSTRUCTION <= NOP_INSTR;
      IF_PC          <= 32'd0;
      IF_PC_PLUS4    <= 32'd0;
      IF_VALID       <= 1'b0;
    end else begin
      state <= state_next;
      if (BRANCH_TAKEN) begin
        PC             <= target;
        IF_INSTRUCTION <= NOP_INSTR;
        IF_VALID       <= 1'b0;
        if (state == FETCH && IMEM_BUSYWAIT) drain_addr <= PC;
      end else if (state == DRAIN || (!STALL && IMEM_BUSYWAIT)) begin
        IF_INSTRUCTION <= NOP_INSTR;
        IF_VALID       <= 1'b0;
      end else if (!STALL) begin
        IF_INSTRUCTION <= IMEM_READDATA;
        IF_PC          <= PC;
        IF_PC_PLUS4    <= pc_plus4;
        IF_VALID       <= 1'b1;
        PC             <= pc_plus4;
      end
    end
  end
endmodule
